// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//
// In-order instruction dispatch buffer between decode and the out-of-order
// back end. Decoded instructions are held in a circular FIFO and issued one
// per cycle from the head. A load/store goes to the load/store buffer and any
// other instruction goes to the reservation station. Every issue also
// allocates a ROB entry. Issued fields are registered, so the to_* outputs
// and the dispatch pulses are valid for exactly the one cycle after the issue
// edge.
//
// Ports
//   clk_in, rst_in     clock; synchronous active-high reset
//   rdy_in             global enable (0 freezes all state, outputs read 0)
//   clear_in           flush on mispredict (empties the queue)
//   in_valid/in_ready  decode handshake; in_ready depends on occupancy only
//   up_*, mem_in_need  decoded instruction fields offered by decode
//   rs_full, lsb_full, rob_full
//                      downstream back-pressure for the current cycle
//   to_*               registered fields of the instruction issued last edge
//   dispatch_*_rdy     one-cycle issue pulses (RS / LSB / ROB)
//   queue_count        current occupancy
// -----------------------------------------------------------------------------
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] up_inst,
  input  logic [ADDR_W-1:0] up_npc,
  input  logic [IMM_W-1:0]  up_imme,
  input  logic [REG_W-1:0]  up_rs1,
  input  logic [REG_W-1:0]  up_rs2,
  input  logic [REG_W-1:0]  up_rd,
  input  logic              up_rs1_in_need,
  input  logic              up_rs2_in_need,
  input  logic              up_rd_in_need,
  input  logic              mem_in_need,
  input  logic              rs_full,
  input  logic              lsb_full,
  input  logic              rob_full,
  output logic [INST_W-1:0] to_inst,
  output logic [ADDR_W-1:0] to_npc,
  output logic [IMM_W-1:0]  to_imme,
  output logic [REG_W-1:0]  to_rs1,
  output logic [REG_W-1:0]  to_rs2,
  output logic [REG_W-1:0]  to_rd,
  output logic              to_rs1_in_need,
  output logic              to_rs2_in_need,
  output logic              to_rd_in_need,
  output logic              dispatch_rs_rdy,
  output logic              dispatch_lsb_rdy,
  output logic              dispatch_rob_rdy,
  output logic [CNT_W-1:0]  queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] npc;
    logic [IMM_W-1:0]  imme;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rs1_need;
    logic              rs2_need;
    logic              rd_need;
    logic              mem;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Issued entry and its valid flag. The mem bit of out_q selects which of
  // the RS/LSB pulses fires, so only one pulse flop is needed.
  entry_t           out_q, out_d;
  logic             issued_q, issued_d;

  entry_t           up_ent;
  entry_t           head_ent;
  logic             target_full;
  logic             do_issue;
  logic             do_enq;

  assign up_ent = '{
    inst:     up_inst,
    npc:      up_npc,
    imme:     up_imme,
    rs1:      up_rs1,
    rs2:      up_rs2,
    rd:       up_rd,
    rs1_need: up_rs1_in_need,
    rs2_need: up_rs2_in_need,
    rd_need:  up_rd_in_need,
    mem:      mem_in_need
  };

  assign head_ent    = mem_q[head_q];
  assign in_ready    = (count_q < DEPTH_C);
  assign target_full = head_ent.mem ? lsb_full : rs_full;

  // Issue decisions use only registered state, so an entry written at this
  // edge can never leave at the same edge.
  assign do_issue = (count_q != '0) && !rob_full && !target_full &&
                    rdy_in && !clear_in && !rst_in;
  assign do_enq   = in_valid && in_ready && rdy_in && !clear_in && !rst_in;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    out_d    = '0;
    issued_d = 1'b0;

    if (clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy_in) begin
      if (do_issue) begin
        head_d   = head_q + PTR_W'(1);
        issued_d = 1'b1;
        out_d    = head_ent;
        // x0 is never a real destination; drop it before it reaches rename.
        out_d.rd_need = head_ent.rd_need && (head_ent.rd != '0);
        out_d.rd      = out_d.rd_need ? head_ent.rd : '0;
      end
      if (do_enq) begin
        tail_d = tail_q + PTR_W'(1);
      end
      unique case ({do_enq, do_issue})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      out_q    <= out_d;
      issued_q <= issued_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (do_enq) begin
      mem_q[tail_q] <= up_ent;
    end
  end

  assign to_inst          = out_q.inst;
  assign to_npc           = out_q.npc;
  assign to_imme          = out_q.imme;
  assign to_rs1           = out_q.rs1;
  assign to_rs2           = out_q.rs2;
  assign to_rd            = out_q.rd;
  assign to_rs1_in_need   = out_q.rs1_need;
  assign to_rs2_in_need   = out_q.rs2_need;
  assign to_rd_in_need    = out_q.rd_need;
  assign dispatch_rob_rdy = issued_q;
  assign dispatch_lsb_rdy = issued_q && out_q.mem;
  assign dispatch_rs_rdy  = issued_q && !out_q.mem;
  assign queue_count      = count_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_dispatch_queue
//
// Self-checking bench for dispatch_queue. Every cycle is predicted by a
// reference model that keeps the pending instructions in a plain queue and
// applies the dispatch rules directly. The directed part is a table of
// {inputs, expected outputs} records plus short hand-written sequences for
// multi-cycle corners; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_dispatch_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int IMM_W  = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0, rdy_in = 1'b0, clear_in = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] up_inst = '0;
  logic [ADDR_W-1:0] up_npc = '0;
  logic [IMM_W-1:0]  up_imme = '0;
  logic [REG_W-1:0]  up_rs1 = '0, up_rs2 = '0, up_rd = '0;
  logic              up_rs1_in_need = 1'b0, up_rs2_in_need = 1'b0;
  logic              up_rd_in_need = 1'b0, mem_in_need = 1'b0;
  logic              rs_full = 1'b0, lsb_full = 1'b0, rob_full = 1'b0;
  logic [INST_W-1:0] to_inst;
  logic [ADDR_W-1:0] to_npc;
  logic [IMM_W-1:0]  to_imme;
  logic [REG_W-1:0]  to_rs1, to_rs2, to_rd;
  logic              to_rs1_in_need, to_rs2_in_need, to_rd_in_need;
  logic              dispatch_rs_rdy, dispatch_lsb_rdy, dispatch_rob_rdy;
  logic [CNT_W-1:0]  queue_count;

  dispatch_queue #(
    .DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W),
    .IMM_W(IMM_W), .REG_W(REG_W), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .up_inst(up_inst), .up_npc(up_npc), .up_imme(up_imme),
    .up_rs1(up_rs1), .up_rs2(up_rs2), .up_rd(up_rd),
    .up_rs1_in_need(up_rs1_in_need), .up_rs2_in_need(up_rs2_in_need),
    .up_rd_in_need(up_rd_in_need), .mem_in_need(mem_in_need),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
    .to_inst(to_inst), .to_npc(to_npc), .to_imme(to_imme),
    .to_rs1(to_rs1), .to_rs2(to_rs2), .to_rd(to_rd),
    .to_rs1_in_need(to_rs1_in_need), .to_rs2_in_need(to_rs2_in_need),
    .to_rd_in_need(to_rd_in_need),
    .dispatch_rs_rdy(dispatch_rs_rdy), .dispatch_lsb_rdy(dispatch_lsb_rdy),
    .dispatch_rob_rdy(dispatch_rob_rdy), .queue_count(queue_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    bit rst, rdy, clr, valid, rs_full, lsb_full, rob_full;
  } ctl_t;

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] npc;
    logic [IMM_W-1:0]  imme;
    logic [REG_W-1:0]  rs1, rs2, rd;
    logic              n1, n2, nd, mem;
  } ent_t;

  typedef struct {
    ctl_t       c;
    ent_t       e;
    bit         rs, lsb, rob;
    int         cnt;
    logic [4:0] rd;
    bit         rdn;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ent_t model_q[$];
  bit   exp_issue;
  ent_t exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t mkc(bit rst, bit rdy, bit clr, bit valid, bit rsf, bit lsbf, bit robf);
    ctl_t c;
    c.rst = rst; c.rdy = rdy; c.clr = clr; c.valid = valid;
    c.rs_full = rsf; c.lsb_full = lsbf; c.rob_full = robf;
    return c;
  endfunction

  function automatic ent_t zero_ent();
    ent_t e;
    e.inst = '0; e.npc = '0; e.imme = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.n1 = 1'b0; e.n2 = 1'b0; e.nd = 1'b0; e.mem = 1'b0;
    return e;
  endfunction

  function automatic ent_t mk_ent(logic [31:0] inst, logic [4:0] rd, bit nd, bit mem);
    ent_t e;
    e.inst = inst; e.npc = inst + 32'd4; e.imme = inst ^ 32'h0000_5a5a;
    e.rs1 = rd + 5'd1; e.rs2 = rd + 5'd2; e.rd = rd;
    e.n1 = 1'b1; e.n2 = inst[0]; e.nd = nd; e.mem = mem;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.inst = $urandom; e.npc = $urandom; e.imme = $urandom;
    e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
    e.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    e.n1 = 1'($urandom); e.n2 = 1'($urandom); e.nd = 1'($urandom);
    e.mem = 1'($urandom);
    return e;
  endfunction

  // Apply one cycle of stimulus, advance the reference model, and compare
  // every DUT output just after the edge.
  task automatic step(input ctl_t c, input ent_t e);
    bit   can_issue, can_enq;
    bit   rdn;
    logic [4:0] rd;
    @(negedge clk_in);
    rst_in = c.rst; rdy_in = c.rdy; clear_in = c.clr; in_valid = c.valid;
    rs_full = c.rs_full; lsb_full = c.lsb_full; rob_full = c.rob_full;
    up_inst = e.inst; up_npc = e.npc; up_imme = e.imme;
    up_rs1 = e.rs1; up_rs2 = e.rs2; up_rd = e.rd;
    up_rs1_in_need = e.n1; up_rs2_in_need = e.n2; up_rd_in_need = e.nd;
    mem_in_need = e.mem;

    exp_issue = 1'b0;
    exp_e     = zero_ent();
    if (c.rst || c.clr) begin
      model_q.delete();
    end else if (c.rdy) begin
      can_issue = (model_q.size() > 0) && !c.rob_full &&
                  (model_q[0].mem ? !c.lsb_full : !c.rs_full);
      can_enq   = c.valid && (model_q.size() < DEPTH);
      if (can_issue) begin
        exp_e     = model_q.pop_front();
        exp_issue = 1'b1;
      end
      if (can_enq) model_q.push_back(e);
    end

    @(posedge clk_in);
    #1;
    rdn = exp_issue && exp_e.nd && (exp_e.rd != 5'd0);
    rd  = rdn ? exp_e.rd : 5'd0;
    check("rob_pulse", 64'(dispatch_rob_rdy), 64'(exp_issue));
    check("lsb_pulse", 64'(dispatch_lsb_rdy), 64'(exp_issue && exp_e.mem));
    check("rs_pulse",  64'(dispatch_rs_rdy),  64'(exp_issue && !exp_e.mem));
    check("to_inst",   64'(to_inst), exp_issue ? 64'(exp_e.inst) : 64'd0);
    check("to_npc",    64'(to_npc),  exp_issue ? 64'(exp_e.npc)  : 64'd0);
    check("to_imme",   64'(to_imme), exp_issue ? 64'(exp_e.imme) : 64'd0);
    check("to_regs",
          64'({to_rs1, to_rs2, to_rd, to_rs1_in_need, to_rs2_in_need, to_rd_in_need}),
          exp_issue ? 64'({exp_e.rs1, exp_e.rs2, rd, exp_e.n1, exp_e.n2, rdn}) : 64'd0);
    check("count",     64'(queue_count), 64'(model_q.size()));
    check("in_ready",  64'(in_ready), 64'(model_q.size() < DEPTH));
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    ctl_t idle, offer, offer_robf, rst_c;
    ent_t a5, z, st, young;
    ent_t f[6];

    idle       = mkc(0, 1, 0, 0, 0, 0, 0);
    offer      = mkc(0, 1, 0, 1, 0, 0, 0);
    offer_robf = mkc(0, 1, 0, 1, 0, 0, 1);
    rst_c      = mkc(1, 0, 0, 0, 0, 0, 0);
    a5 = mk_ent(32'h100, 5'd5, 1'b1, 1'b0);
    z  = mk_ent(32'h200, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) f[k] = mk_ent(32'h300 + 32'(k), 5'(k), 1'b1, 1'b0);

    //        ctl         entry        rs lsb rob cnt rd  rdn
    v = '{rst_c,      zero_ent(), 0, 0, 0, 0, 5'd0, 0}; vecs.push_back(v);
    v = '{offer,      a5,         0, 0, 0, 1, 5'd0, 0}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 1, 0, 1, 0, 5'd5, 1}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 0, 0, 0, 0, 5'd0, 0}; vecs.push_back(v);
    v = '{offer,      z,          0, 0, 0, 1, 5'd0, 0}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 1, 0, 1, 0, 5'd0, 0}; vecs.push_back(v);
    v = '{offer_robf, f[1],       0, 0, 0, 1, 5'd0, 0}; vecs.push_back(v);
    v = '{offer_robf, f[2],       0, 0, 0, 2, 5'd0, 0}; vecs.push_back(v);
    v = '{offer_robf, f[3],       0, 0, 0, 3, 5'd0, 0}; vecs.push_back(v);
    v = '{offer_robf, f[4],       0, 0, 0, 4, 5'd0, 0}; vecs.push_back(v);
    v = '{offer_robf, f[5],       0, 0, 0, 4, 5'd0, 0}; vecs.push_back(v);
    v = '{offer,      f[5],       1, 0, 1, 3, 5'd1, 1}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 1, 0, 1, 2, 5'd2, 1}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 1, 0, 1, 1, 5'd3, 1}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 1, 0, 1, 0, 5'd4, 1}; vecs.push_back(v);
    v = '{idle,       zero_ent(), 0, 0, 0, 0, 5'd0, 0}; vecs.push_back(v);

    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].e);
      check($sformatf("vec%0d_rs", i),  64'(dispatch_rs_rdy),  64'(vecs[i].rs));
      check($sformatf("vec%0d_lsb", i), 64'(dispatch_lsb_rdy), 64'(vecs[i].lsb));
      check($sformatf("vec%0d_rob", i), 64'(dispatch_rob_rdy), 64'(vecs[i].rob));
      check($sformatf("vec%0d_cnt", i), 64'(queue_count),      64'(vecs[i].cnt));
      check($sformatf("vec%0d_rd", i),  64'(to_rd),            64'(vecs[i].rd));
      check($sformatf("vec%0d_rdn", i), 64'(to_rd_in_need),    64'(vecs[i].rdn));
    end

    // Store stalled on lsb_full for three cycles; a younger ALU op queued
    // behind it must wait even though the RS is free.
    st    = mk_ent(32'h400, 5'd0, 1'b0, 1'b1);
    young = mk_ent(32'h401, 5'd7, 1'b1, 1'b0);
    step(mkc(0, 1, 0, 1, 0, 1, 0), st);
    step(mkc(0, 1, 0, 1, 0, 1, 0), young);
    step(mkc(0, 1, 0, 0, 0, 1, 0), zero_ent());
    step(mkc(0, 1, 0, 0, 0, 1, 0), zero_ent());
    check("stall_no_issue", 64'(dispatch_rob_rdy), 64'd0);
    step(idle, zero_ent());
    check("store_lsb_pulse", 64'(dispatch_lsb_rdy), 64'd1);
    check("store_inst", 64'(to_inst), 64'h400);
    step(idle, zero_ent());
    check("young_rs_pulse", 64'(dispatch_rs_rdy), 64'd1);
    check("young_rd", 64'(to_rd), 64'd7);

    // rdy_in low freezes the queue and suppresses enqueue.
    step(offer_robf, f[1]);
    step(offer_robf, f[2]);
    step(mkc(0, 0, 0, 1, 0, 0, 0), f[3]);
    step(mkc(0, 0, 0, 1, 0, 0, 0), f[3]);
    check("freeze_count", 64'(queue_count), 64'd2);
    step(idle, zero_ent());
    step(idle, zero_ent());

    // Three queued, then clear with rdy_in low; next entry flows normally.
    step(offer_robf, f[1]);
    step(offer_robf, f[2]);
    step(offer_robf, f[3]);
    step(mkc(0, 0, 1, 0, 0, 0, 0), zero_ent());
    check("clear_count", 64'(queue_count), 64'd0);
    check("clear_no_pulse", 64'(dispatch_rob_rdy), 64'd0);
    step(offer, a5);
    step(idle, zero_ent());
    check("post_clear_rs", 64'(dispatch_rs_rdy), 64'd1);
    check("post_clear_inst", 64'(to_inst), 64'h100);

    // Reset mid-stream discards pending entries (and ignores the offer).
    step(offer_robf, f[4]);
    step(offer_robf, f[5]);
    step(mkc(1, 1, 0, 1, 0, 0, 0), f[1]);
    check("rst_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) step(idle, zero_ent());
    check("rst_nothing_issued", 64'(dispatch_rob_rdy), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ctl_t c;
      c = mkc($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0);
      step(c, rand_ent());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 4, queue entries; power of two, at least 2.
- INST_W, 32, instruction width.
- ADDR_W, 32, npc width.
- IMM_W, 32, immediate width.
- REG_W, 5, register index width.
- CNT_W, $clog2(DEPTH)+1, occupancy width.
REQ-002 Ports SHALL be (clock and reset first):
- clk_in  in  1  sole clock.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; 0 freezes the block.
- clear_in  in  1  flush from ROB (mispredict).
- in_valid  in  1  decode offers an entry.
- in_ready  out  1  queue can accept.
- up_inst  in  INST_W  instruction.
- up_npc  in  ADDR_W  next pc.
- up_imme  in  IMM_W  immediate.
- up_rs1, up_rs2, up_rd  in  REG_W each  register indices.
- up_rs1_in_need, up_rs2_in_need, up_rd_in_need  in  1 each  register used.
- mem_in_need  in  1  1 = load/store (LSB), 0 = RS.
- rs_full, lsb_full, rob_full  in  1 each  downstream cannot accept this cycle.
- to_inst, to_npc, to_imme, to_rs1, to_rs2, to_rd, to_rs1_in_need, to_rs2_in_need, to_rd_in_need  out  same widths as up_*  registered issued fields.
- dispatch_rs_rdy, dispatch_lsb_rdy, dispatch_rob_rdy  out  1 each  one-cycle issue pulses.
- queue_count  out  CNT_W  current occupancy.

Function
REQ-003 Block SHALL hold a circular FIFO of DEPTH entries storing all up_* fields plus mem_in_need; head/tail pointers wrap modulo DEPTH.
REQ-004 in_ready SHALL equal (queue_count < DEPTH), combinational from state only; no ready-on-dequeue pass-through.
REQ-005 Enqueue SHALL occur at the edge where in_valid && in_ready && rdy_in && !clear_in && !rst_in.
REQ-006 Issue condition SHALL be: queue_count > 0, rob_full == 0, target not full (lsb_full if head mem_in_need else rs_full), rdy_in == 1, clear_in == 0.
REQ-007 On issue, at that edge the head entry SHALL be popped and registered onto to_* outputs; dispatch_rob_rdy = 1; dispatch_lsb_rdy = 1 if mem_in_need, else dispatch_rs_rdy = 1.
REQ-008 Every edge without issue SHALL drive all to_* outputs and all three pulses to 0.
REQ-009 Minimum latency: entry accepted at edge N SHALL be issuable no earlier than edge N+1; there is no decode-to-output bypass.
REQ-010 Issue SHALL be strictly in order; a stalled head blocks all younger entries regardless of their target.
REQ-011 to_rd_in_need SHALL be up_rd_in_need && (up_rd != 0); to_rd SHALL be up_rd when to_rd_in_need is 1, else 0; rs1/rs2 indices and need bits pass unmodified.
REQ-012 Simultaneous enqueue and issue SHALL leave queue_count unchanged; when full, no enqueue occurs even if issuing that edge.
REQ-013 rdy_in == 0 SHALL hold the pointers, storage and queue_count, and zero the pulses and to_* outputs.
REQ-014 clear_in == 1 (regardless of rdy_in) SHALL set queue_count to 0 and reset the pointers to 0 at that edge; no enqueue, no issue, outputs zeroed.
REQ-015 Priority SHALL be rst_in > clear_in > rdy_in.

Reset
REQ-016 rst_in SHALL, at the edge, zero queue_count, pointers, all to_* outputs and all pulses; in_ready SHALL read 1 the following cycle.
REQ-017 rst_in asserted mid-stream SHALL discard all queued entries; nothing pending SHALL issue after release.

Verification
REQ-018 Bench SHALL cover:
- Reset, then enqueue one ALU instruction (rd=5, rd_need=1) with no stalls -> next edge dispatch_rs_rdy=1, dispatch_rob_rdy=1, to_rd=5; then all outputs 0.
- Enqueue a store at edge N with lsb_full=1 for 3 cycles -> no issue; dispatch_lsb_rdy pulses at the first edge after lsb_full drops.
- DEPTH=4, rob_full=1, 5 offers -> 4 accepted, in_ready=0, queue_count=4; release rob_full -> 4 in-order issues, one per cycle.
- Full queue with simultaneous issue and in_valid=1 -> no enqueue that edge, queue_count 4 -> 3.
- rd=0, rd_need=1 -> to_rd=0, to_rd_in_need=0.
- 3 entries queued, clear_in=1 with rdy_in=0 -> queue_count=0, no pulse; next enqueue issues normally with pointers wrapped from 0.
